// File: rtl/rns_sub_scheduler_pkg.sv
// Shared RNS definitions: residue width, FSM encodings
// and the default moduli set used by the channel schedulers.
package rns_sub_scheduler_pkg;

  localparam int RNS_W = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_CORR = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4*RNS_W-1:0] DEF_MODULI =
    {6'd63, 6'd61, 6'd59, 6'd55};

  // 64 - m, so that d - (64 - m) == d + m mod 64
  function automatic logic [RNS_W-1:0] neg_mod(
    input logic [RNS_W-1:0] m
  );
    return ~m + 1'b1;
  endfunction

endpackage

// File: rtl/rns_sub_scheduler_if.sv
// Operand/result handshake bundle between the RNS
// operand register file and the reverse-conversion stage.
interface rns_sub_scheduler_if #(
  parameter int NUM_CH = 4
);
  import rns_sub_scheduler_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [RNS_W*NUM_CH-1:0] in_a;
  logic [RNS_W*NUM_CH-1:0] in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [RNS_W*NUM_CH-1:0] out_r;
  logic                    out_err;
  logic                    busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_r, out_err, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_r, out_err, busy
  );

endinterface

// File: rtl/rns_sub_scheduler_subtractor.sv
// Shared 6-bit two's-complement subtractor (SUBTRACTOR_6_BIT),
// time-shared by the scheduler across all residue channels.
module rns_sub_scheduler_subtractor
  import rns_sub_scheduler_pkg::*;
(
  input  logic [RNS_W-1:0] i_a,
  input  logic [RNS_W-1:0] i_b,
  output logic [RNS_W-1:0] o_d
);

  assign o_d = i_a + ~i_b + 1'b1;

endmodule

// File: rtl/rns_sub_scheduler.sv
// Sequences one RNS modular subtraction (a - b) mod m_i,
// one channel per cycle plus one correction cycle per borrow.
module rns_sub_scheduler
  import rns_sub_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter logic [RNS_W*NUM_CH-1:0] MODULI = DEF_MODULI
) (
  input logic               clk,
  input logic               rst,
  rns_sub_scheduler_if.slave bus
);

  localparam int VW = RNS_W * NUM_CH;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_ch;
  logic [VW-1:0]    r_a;
  logic [VW-1:0]    r_b;
  logic [VW-1:0]    r_r;
  logic [RNS_W-1:0] r_d;
  logic             r_err;

  logic [RNS_W-1:0] w_ach;
  logic [RNS_W-1:0] w_bch;
  logic [RNS_W-1:0] w_mch;
  logic [RNS_W-1:0] w_sa;
  logic [RNS_W-1:0] w_sb;
  logic [RNS_W-1:0] w_d;
  logic             w_borrow;
  logic             w_range_err;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_wr;
  logic             w_last;

  always_comb begin
    w_ach = '0;
    w_bch = '0;
    w_mch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == CW'(i)) begin
        w_ach = r_a[RNS_W*i +: RNS_W];
        w_bch = r_b[RNS_W*i +: RNS_W];
        w_mch = MODULI[RNS_W*i +: RNS_W];
      end
    end
  end

  always_comb begin
    w_range_err = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_range_err = w_range_err
        | (bus.in_a[RNS_W*i +: RNS_W]
           >= MODULI[RNS_W*i +: RNS_W])
        | (bus.in_b[RNS_W*i +: RNS_W]
           >= MODULI[RNS_W*i +: RNS_W]);
    end
  end

  // Single operand pair into the shared subtractor
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    unique case (1'b1)
      (r_state == S_SUB): begin
        w_sa = w_ach;
        w_sb = w_bch;
      end
      (r_state == S_CORR): begin
        w_sa = r_d;
        w_sb = neg_mod(w_mch);
      end
      default: begin
        w_sa = '0;
        w_sb = '0;
      end
    endcase
  end

  rns_sub_scheduler_subtractor u_sub (
    .i_a (w_sa),
    .i_b (w_sb),
    .o_d (w_d)
  );

  assign w_borrow   = (w_ach < w_bch);
  assign w_in_fire  = bus.in_valid & (r_state == S_IDLE);
  assign w_out_fire = bus.out_ready & (r_state == S_DONE);
  assign w_last     = (r_ch == LAST);
  assign w_wr       = ((r_state == S_SUB) & ~w_borrow)
                    | (r_state == S_CORR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_wr) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_ch == CW'(i))
            r_r[RNS_W*i +: RNS_W] <= w_d;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_err   <= w_range_err;
            r_ch    <= '0;
            r_state <= S_SUB;
          end
        end
        S_SUB: begin
          if (w_borrow) begin
            r_d     <= w_d;
            r_state <= S_CORR;
          end else if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_ch    <= r_ch + 1'b1;
          end
        end
        S_CORR: begin
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_state <= S_SUB;
          end
        end
        S_DONE: begin
          if (w_out_fire)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_r     = r_r;
  assign bus.out_err   = r_err;

endmodule
